// File: rtl/int_axi4l.sv
// int_axi4l: internal register strobe to AXI4-Lite master bridge.
// One transaction in flight; a write+read pair runs write first.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn      clock, async active-low reset
//   int_addr/int_wr_data/int_wr_strb/int_wr_en/int_rd_en
//                                  internal request (single-cycle strobes)
//   int_wr_ack/int_wr_err          write completion pulse and error flag
//   int_rd_ack/int_rd_err/int_rd_data
//                                  read completion pulse, error, held data
//   int_busy, int_ovr              activity flag, dropped-request pulse
//   m_axi_*                        AXI4-Lite master channels
module int_axi4l #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   int_addr,
    input  logic [DATA_WIDTH-1:0]   int_wr_data,
    input  logic [DATA_WIDTH/8-1:0] int_wr_strb,
    input  logic                    int_wr_en,
    input  logic                    int_rd_en,
    output logic                    int_wr_ack,
    output logic                    int_wr_err,
    output logic                    int_rd_ack,
    output logic                    int_rd_err,
    output logic [DATA_WIDTH-1:0]   int_rd_data,
    output logic                    int_busy,
    output logic                    int_ovr,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]           wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    pend_q, pend_d;
    logic                    wr_ack_q, wr_ack_d;
    logic                    wr_err_q, wr_err_d;
    logic                    rd_ack_q, rd_ack_d;
    logic                    rd_err_q, rd_err_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    ovr_q, ovr_d;

    logic busy;
    logic aw_done;
    logic w_done;

    assign busy = (state_q != IDLE) || pend_q;

    // A channel counts as done once its valid has dropped or is
    // handshaking this cycle; lets AW and W finish in either order.
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q || m_axi_wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        pend_d    = pend_q;
        rd_data_d = rd_data_q;
        wr_ack_d  = 1'b0;
        wr_err_d  = 1'b0;
        rd_ack_d  = 1'b0;
        rd_err_d  = 1'b0;
        ovr_d     = 1'b0;

        // Any strobe seen while busy is dropped; a combined
        // write+read strobe still yields one pulse.
        if (busy && (int_wr_en || int_rd_en)) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (int_wr_en) begin
                    addr_d    = int_addr;
                    wdata_d   = int_wr_data;
                    wstrb_d   = int_wr_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    pend_d    = int_rd_en;
                    state_d   = WR_REQ;
                end else if (int_rd_en) begin
                    addr_d    = int_addr;
                    arvalid_d = 1'b1;
                    state_d   = RD_REQ;
                end
            end
            WR_REQ: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    wr_ack_d = 1'b1;
                    wr_err_d = (m_axi_bresp != 2'b00);
                    if (pend_q) begin
                        // Pending read reuses the write address.
                        pend_d    = 1'b0;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi_rvalid) begin
                    rd_data_d = m_axi_rdata;
                    rd_err_d  = (m_axi_rresp != 2'b00);
                    rd_ack_d  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            pend_q    <= 1'b0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            pend_q    <= pend_d;
            wr_ack_q  <= wr_ack_d;
            wr_err_q  <= wr_err_d;
            rd_ack_q  <= rd_ack_d;
            rd_err_q  <= rd_err_d;
            rd_data_q <= rd_data_d;
            ovr_q     <= ovr_d;
        end
    end

    assign int_wr_ack    = wr_ack_q;
    assign int_wr_err    = wr_err_q;
    assign int_rd_ack    = rd_ack_q;
    assign int_rd_err    = rd_err_q;
    assign int_rd_data   = rd_data_q;
    assign int_busy      = busy;
    assign int_ovr       = ovr_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == RD_RESP);

endmodule

// File: tb/tb_int_axi4l.sv
// tb_int_axi4l: directed bench for int_axi4l with a scoreboard.
// Stimulus pushes expected acks/requests; monitors pop and compare.
module tb_int_axi4l;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] int_addr = '0;
    logic [DW-1:0] int_wr_data = '0;
    logic [SW-1:0] int_wr_strb = '0;
    logic          int_wr_en = 1'b0;
    logic          int_rd_en = 1'b0;
    logic          int_wr_ack, int_wr_err;
    logic          int_rd_ack, int_rd_err;
    logic [DW-1:0] int_rd_data;
    logic          int_busy, int_ovr;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, arvalid, bready, rready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic          bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic [DW-1:0] rdata = '0;

    always #5 clk = ~clk;

    int_axi4l #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .int_addr      (int_addr),
        .int_wr_data   (int_wr_data),
        .int_wr_strb   (int_wr_strb),
        .int_wr_en     (int_wr_en),
        .int_rd_en     (int_rd_en),
        .int_wr_ack    (int_wr_ack),
        .int_wr_err    (int_wr_err),
        .int_rd_ack    (int_rd_ack),
        .int_rd_err    (int_rd_err),
        .int_rd_data   (int_rd_data),
        .int_busy      (int_busy),
        .int_ovr       (int_ovr),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    typedef struct {
        bit          is_rd;
        bit          err;
        logic [31:0] data;
        int          t0;
        int          lat;
    } resp_t;

    resp_t          exp_q[$];
    logic [AW-1:0]  awq[$];
    logic [AW-1:0]  arq[$];
    logic [35:0]    wq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
    bit b_block = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    int aw_len = 0, w_len = 0;
    int aw_len_last = 0, w_len_last = 0;
    int ovr_cnt = 0, ar_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Slave model: each ready/valid rises after its configured delay.
    initial begin
        int aw_c, w_c, ar_c, b_c, r_c;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                awready = 0; wready = 0; arready = 0;
                bvalid = 0; rvalid = 0;
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
            end else begin
                if (awvalid) begin
                    awready = (aw_c >= aw_dly); aw_c++;
                end else begin
                    awready = 0; aw_c = 0;
                end
                if (wvalid) begin
                    wready = (w_c >= w_dly); w_c++;
                end else begin
                    wready = 0; w_c = 0;
                end
                if (arvalid) begin
                    arready = (ar_c >= ar_dly); ar_c++;
                end else begin
                    arready = 0; ar_c = 0;
                end
                if (bready && !b_block) begin
                    bvalid = (b_c >= b_dly); b_c++;
                end else begin
                    bvalid = 0; b_c = 0;
                end
                if (rready) begin
                    rvalid = (r_c >= r_dly); r_c++;
                end else begin
                    rvalid = 0; r_c = 0;
                end
                bresp = bresp_cfg;
                rresp = rresp_cfg;
                rdata = rdata_cfg;
            end
        end
    end

    // Monitor: compares every handshake and ack against the queues.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (int_ovr) ovr_cnt++;
                if (arvalid) ar_cyc++;
                if (awvalid) aw_len++;
                if (wvalid) w_len++;
                if (awvalid && awready) begin
                    aw_len_last = aw_len; aw_len = 0;
                    if (awq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL aw_unexpected: got %0h", awaddr);
                    end else begin
                        chk("awaddr", awaddr, awq.pop_front());
                    end
                end
                if (wvalid && wready) begin
                    w_len_last = w_len; w_len = 0;
                    if (wq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w_unexpected: got %0h", wdata);
                    end else begin
                        chk("wdata_strb", {wstrb, wdata}, wq.pop_front());
                    end
                end
                if (arvalid && arready) begin
                    if (arq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ar_unexpected: got %0h", araddr);
                    end else begin
                        chk("araddr", araddr, arq.pop_front());
                    end
                end
                if (int_wr_ack || int_rd_ack) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ack_unexpected: got wr=%0d rd=%0d want none",
                                 int_wr_ack, int_rd_ack);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_kind", {int_wr_ack, int_rd_ack},
                            e.is_rd ? 2'b01 : 2'b10);
                        if (e.is_rd) begin
                            chk("rd_err", int_rd_err, e.err);
                            chk("rd_data", int_rd_data, e.data);
                        end else begin
                            chk("wr_err", int_wr_err, e.err);
                        end
                        if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
                    end
                end
            end
        end
    end

    // Drives one strobe cycle (cycle 0); returns early in cycle 1.
    task automatic issue(input bit wr, input bit rd, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input bit push, input bit werr, input bit rerr,
                         input logic [31:0] rexp, input int wlat,
                         input int rlat);
        @(posedge clk);
        #1;
        int_wr_en = wr; int_rd_en = rd;
        int_addr = a; int_wr_data = d; int_wr_strb = s;
        if (push) begin
            if (wr) begin
                exp_q.push_back('{1'b0, werr, 32'h0, cyc, wlat});
                awq.push_back(a);
                wq.push_back({s, d});
            end
            if (rd) begin
                exp_q.push_back('{1'b1, rerr, rexp, cyc, rlat});
                arq.push_back(a);
            end
        end
        @(posedge clk);
        #1;
        int_wr_en = 0; int_rd_en = 0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || int_busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() != 0 || int_busy) begin
            checks++; errors++;
            $display("FAIL timeout: pending=%0d busy=%0d want 0 0",
                     exp_q.size(), int_busy);
            exp_q.delete(); awq.delete(); wq.delete(); arq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_acks", {int_wr_ack, int_rd_ack, int_wr_err, int_rd_err}, 0);
        chk("rst_ovr", int_ovr, 0);
        chk("rst_busy", int_busy, 0);
        chk("rst_rd_data", int_rd_data, 0);
        chk("rst_addrs", {awaddr, araddr}, 0);
        chk("rst_wdata", {wstrb, wdata}, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // Zero-wait write
        issue(1, 0, 10'h004, 32'hDEADBEEF, 4'hF, 1, 0, 0, 0, 3, -1);
        @(negedge clk);
        chk("t1_awvalid", {awvalid, wvalid}, 2'b11);
        chk("t1_awaddr", awaddr, 10'h004);
        chk("t1_wdata", wdata, 32'hDEADBEEF);
        chk("t1_prot", {awprot, arprot}, 0);
        wait_done(50);

        // Delayed W, SLVERR response
        w_dly = 4; bresp_cfg = 2'b10;
        issue(1, 0, 10'h008, 32'hA5A50F0F, 4'b0101, 1, 1, 0, 0, 7, -1);
        wait_done(50);
        chk("t2_aw_len", aw_len_last, 1);
        chk("t2_w_len", w_len_last, 5);
        w_dly = 0; bresp_cfg = 2'b00;

        // Delayed read
        ar_dly = 2; r_dly = 3; rdata_cfg = 32'h12345678;
        issue(0, 1, 10'h010, 0, 0, 1, 0, 0, 32'h12345678, -1, 8);
        wait_done(50);
        ar_dly = 0; r_dly = 0; rdata_cfg = 32'hFFFF0000;
        issue(1, 0, 10'h00C, 32'h0, 4'h3, 1, 0, 0, 0, 3, -1);
        wait_done(50);
        chk("t3_rd_hold", int_rd_data, 32'h12345678);

        // Simultaneous write and read
        rdata_cfg = 32'h55AA33CC;
        issue(1, 1, 10'h020, 32'h0BADF00D, 4'hF, 1, 0, 0,
              32'h55AA33CC, 3, 5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t4_busy_c%0d", k), int_busy, (k < 5));
            chk($sformatf("t4_arvalid_c%0d", k), arvalid, (k == 3));
        end
        wait_done(50);

        // Requests while busy are dropped
        b_block = 1; ovr_cnt = 0; ar_cyc = 0;
        issue(1, 0, 10'h030, 32'h11112222, 4'hF, 1, 0, 0, 0, -1, -1);
        issue(0, 1, 10'h034, 0, 0, 0, 0, 0, 0, -1, -1);
        @(negedge clk);
        chk("t5_ovr_first", ovr_cnt, 1);
        repeat (3) @(posedge clk);
        issue(1, 1, 10'h038, 32'h33334444, 4'hF, 0, 0, 0, 0, -1, -1);
        repeat (3) @(posedge clk);
        #1 b_block = 0;
        wait_done(50);
        chk("t5_ovr_cnt", ovr_cnt, 2);
        chk("t5_no_ar", ar_cyc, 0);

        // Reset during a stalled read
        ar_dly = 20;
        issue(0, 1, 10'h040, 0, 0, 0, 0, 0, 0, -1, -1);
        @(negedge clk);
        chk("t6_arvalid_pre", arvalid, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_arvalid_rst", arvalid, 0);
        chk("t6_busy_rst", int_busy, 0);
        chk("t6_araddr_rst", araddr, 0);
        repeat (2) @(posedge clk);
        ar_dly = 0; rdata_cfg = 32'hCAFEF00D;
        @(posedge clk);
        #1 rst_n = 1;
        repeat (3) @(negedge clk);
        issue(0, 1, 10'h3FC, 0, 0, 1, 0, 0, 32'hCAFEF00D, -1, 3);
        wait_done(50);

        chk("left_aw", awq.size(), 0);
        chk("left_w", wq.size(), 0);
        chk("left_ar", arq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
